bcd_operand_entry: RTL and testbench
====================================

Name: bcd_operand_entry

Overview:
Keypad-driven operand entry controller directly upstream of the single-digit BCD adder (dec_adder). It consumes one-cycle key events from the keypad scanner and builds two BCD operands, num_0 and num_1, which drive the adder inputs. It also provides digit-blanking and status flags to the seven-segment display stage. A small FSM sequences the flow "A, +, B, =". An optional hold timer returns the block to idle after a result has been shown.

Parameters:
- TIMEOUT, default 100_000_000: clock cycles spent in S_DONE before an automatic clear. A value of 0 disables the timer.
- TIMER_W, default 27: timer counter width. Must satisfy 2^TIMER_W > TIMEOUT.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- key_valid  in  1  one-cycle pulse; key_code is valid in that cycle
- key_code  in  4  0-9 digit, 4'hA ADD, 4'hB EQUAL, 4'hC CLEAR, 4'hD-4'hF reserved
- num_0  out  4  operand A (BCD 0-9), to adder num_0
- num_1  out  4  operand B (BCD 0-9), to adder num_1
- state  out  2  current FSM state: 2'b00 S_A, 2'b01 S_B, 2'b10 S_DONE
- op_valid  out  1  high while in S_DONE; operands are final
- blank  out  4  display blanking, 1 = blank. Bit 0 = A digit, bit 1 = B digit, bits 3:2 = result digits
- key_err  out  1  one-cycle pulse on a reserved key code

Behaviour:
- All outputs are registered. Every output updates on the clk edge that samples key_valid = 1, so latency is 1 cycle.
- Reset values (asynchronous, rst = 0): state S_A, num_0 = 0, num_1 = 0, op_valid = 0, blank = 4'b1111, key_err = 0, timer = 0.
- Internal flags: a_seen and b_seen, both cleared on reset and on CLEAR.
- When key_valid = 0, nothing changes except the timer.
- S_A:
  - digit d: num_0 <= d, blank[0] <= 0, a_seen <= 1. Digits overwrite, so the last digit wins.
  - ADD: if a_seen, go to S_B; otherwise ignore.
  - EQUAL: ignored.
- S_B:
  - digit d: num_1 <= d, blank[1] <= 0, b_seen <= 1.
  - EQUAL: if b_seen, go to S_DONE, op_valid <= 1, blank[3:2] <= 2'b00; otherwise ignore.
  - ADD: ignored.
- S_DONE:
  - digit d: start a new entry. num_0 <= d, num_1 <= 0, blank <= 4'b1110, a_seen <= 1, b_seen <= 0, op_valid <= 0, go to S_A.
  - ADD and EQUAL: ignored.
- CLEAR, in any state: all registers return to their reset values on the next edge.
- Reserved codes (D-F), in any state: no state or data change; key_err = 1 for exactly the next cycle.
- Timer:
  - Counts only in S_DONE. It is zeroed on entry to S_DONE and whenever the state is not S_DONE.
  - When timer == TIMEOUT-1 with no key in that cycle, perform a CLEAR on the next edge.
  - If a key arrives in the same cycle as the expiry, the key takes priority and the timer is zeroed.
- Key codes are 4 bits wide. num_0 and num_1 never hold values above 9, because only codes 0-9 are written into them.
- Reset asserted mid-entry takes effect immediately and discards any partial operands.

Optional Feature:
- Macro: AUTO_ADVANCE_EN.
- Defined:
  - A digit in S_A also moves the FSM to S_B in the same edge.
  - A digit in S_B also moves the FSM to S_DONE, with op_valid and blank set as for EQUAL.
  - ADD and EQUAL then behave as ignored keys; they do not raise key_err.
- Undefined: the explicit ADD/EQUAL flow described above.

Decomposition:
- Package bcd_entry_pkg holds:
  - key code constants KEY_ADD = 4'hA, KEY_EQ = 4'hB, KEY_CLR = 4'hC;
  - state encodings S_A, S_B, S_DONE;
  - the blank pattern constants BLANK_ALL = 4'b1111 and BLANK_NEW = 4'b1110.
- One sub-module, entry_hold_timer: the TIMER_W counter with clr/en inputs and an expire output. It is instantiated once.

Test Plan:
1. Reset, then keys 7, ADD, 5, EQUAL (one pulse each, 3 idle cycles apart) -> num_0 = 7, num_1 = 5, state = 2'b10, op_valid = 1, blank = 4'b0000. Downstream adder gives cout = 1, sum = 4'd2 one cycle later.
2. From reset, send ADD then EQUAL -> both ignored, state stays 2'b00, blank = 4'b1111. Then keys 3, 8 -> num_0 = 8.
3. In S_B after 4, ADD, 6, send CLEAR -> next cycle num_0 = 0, num_1 = 0, state = 2'b00, blank = 4'b1111.
4. Key 4'hE in S_A -> key_err high for exactly 1 cycle; num_0 and state unchanged.
5. With TIMEOUT = 10: enter S_DONE, apply no keys -> auto-clear after exactly 10 cycles in S_DONE. Repeat with digit 2 at cycle 9 -> state S_A, num_0 = 2, blank = 4'b1110.
6. Assert rst for 1 cycle mid-entry (S_B, num_1 = 9) -> all outputs return to reset values asynchronously; with AUTO_ADVANCE_EN defined, keys 1, 2 -> S_DONE with num_0 = 1, num_1 = 2.

Source files
------------

// File: rtl/bcd_entry_pkg.sv
// bcd_entry_pkg: shared key codes, FSM states and blanking patterns for bcd_operand_entry.
package bcd_entry_pkg;
  localparam logic [3:0] KEY_ADD   = 4'hA;
  localparam logic [3:0] KEY_EQ    = 4'hB;
  localparam logic [3:0] KEY_CLR   = 4'hC;
  localparam logic [3:0] BLANK_ALL = 4'b1111;
  localparam logic [3:0] BLANK_NEW = 4'b1110;
  typedef enum logic [1:0] {S_A = 2'b00, S_B = 2'b01, S_DONE = 2'b10} state_t;
endpackage

// File: rtl/entry_hold_timer.sv
// entry_hold_timer: hold counter that flags expiry after TIMEOUT enabled cycles (TIMEOUT = 0 disables).
module entry_hold_timer #(
  parameter int TIMEOUT = 100_000_000,
  parameter int TIMER_W = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [TIMER_W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_cnt <= '0;
    else r_cnt <= (clr || !en) ? '0 : r_cnt + 1'b1;
  assign expire = (TIMEOUT != 0) && en && !clr && (r_cnt == TIMER_W'(TIMEOUT - 1));
endmodule

// File: rtl/bcd_operand_entry.sv
// bcd_operand_entry: keypad "A + B =" operand entry for the BCD adder.
// Define AUTO_ADVANCE_EN to advance on each digit instead of using ADD/EQUAL keys.
module bcd_operand_entry
  import bcd_entry_pkg::*;
#(
  parameter int TIMEOUT = 100_000_000,
  parameter int TIMER_W = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] num_0,
  output logic [3:0] num_1,
  output logic [1:0] state,
  output logic       op_valid,
  output logic [3:0] blank,
  output logic       key_err
);
  state_t     r_state, w_state;
  logic [3:0] r_num_0, w_num_0, r_num_1, w_num_1, r_blank, w_blank;
  logic       r_op, w_op, r_err, w_err, r_a_seen, w_a_seen, r_b_seen, w_b_seen;
  logic       w_digit, w_clr, w_expire, w_go_b, w_go_done;
  assign w_digit = key_code <= 4'd9;
  assign w_clr   = w_expire || (key_valid && key_code == KEY_CLR);
`ifdef AUTO_ADVANCE_EN
  assign w_go_b    = w_digit;
  assign w_go_done = w_digit;
`else
  assign w_go_b    = key_code == KEY_ADD && r_a_seen;
  assign w_go_done = key_code == KEY_EQ && r_b_seen;
`endif
  entry_hold_timer #(.TIMEOUT(TIMEOUT), .TIMER_W(TIMER_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (key_valid || r_state != S_DONE),
    .en     (r_state == S_DONE),
    .expire (w_expire)
  );
  always_comb begin
    w_state  = r_state;
    w_num_0  = r_num_0;
    w_num_1  = r_num_1;
    w_blank  = r_blank;
    w_op     = r_op;
    w_a_seen = r_a_seen;
    w_b_seen = r_b_seen;
    w_err    = 1'b0;
    if (w_clr) begin
      w_state  = S_A;
      w_num_0  = '0;
      w_num_1  = '0;
      w_blank  = BLANK_ALL;
      w_op     = 1'b0;
      w_a_seen = 1'b0;
      w_b_seen = 1'b0;
    end else if (key_valid) begin
      if (key_code > KEY_CLR) w_err = 1'b1;
      else if (r_state == S_DONE) begin
        if (w_digit) begin
          w_state  = S_A;
          w_num_0  = key_code;
          w_num_1  = '0;
          w_blank  = BLANK_NEW;
          w_op     = 1'b0;
          w_a_seen = 1'b1;
          w_b_seen = 1'b0;
        end
      end else if (r_state == S_B) begin
        if (w_digit) begin
          w_num_1  = key_code;
          w_blank[1] = 1'b0;
          w_b_seen = 1'b1;
        end
        if (w_go_done) begin
          w_state = S_DONE;
          w_op    = 1'b1;
          w_blank[3:2] = 2'b00;
        end
      end else begin
        if (w_digit) begin
          w_num_0  = key_code;
          w_blank[0] = 1'b0;
          w_a_seen = 1'b1;
        end
        if (w_go_b) w_state = S_B;
      end
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state  <= S_A;
      r_num_0  <= '0;
      r_num_1  <= '0;
      r_blank  <= BLANK_ALL;
      r_op     <= 1'b0;
      r_err    <= 1'b0;
      r_a_seen <= 1'b0;
      r_b_seen <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_num_0  <= w_num_0;
      r_num_1  <= w_num_1;
      r_blank  <= w_blank;
      r_op     <= w_op;
      r_err    <= w_err;
      r_a_seen <= w_a_seen;
      r_b_seen <= w_b_seen;
    end
  assign num_0    = r_num_0;
  assign num_1    = r_num_1;
  assign state    = r_state;
  assign op_valid = r_op;
  assign blank    = r_blank;
  assign key_err  = r_err;
endmodule

// File: tb/tb_bcd_operand_entry.sv
// tb_bcd_operand_entry: directed scoreboard bench for bcd_operand_entry with TIMEOUT = 10.
module tb_bcd_operand_entry;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [3:0] num_0, num_1, blank;
  logic [1:0] state;
  logic       op_valid, key_err;
  int vectors = 0;
  int miscompares = 0;
  typedef struct {
    string      tag;
    logic [15:0] v;
  } exp_t;
  exp_t q[$];
  bcd_operand_entry #(.TIMEOUT(10), .TIMER_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .num_0     (num_0),
    .num_1     (num_1),
    .state     (state),
    .op_valid  (op_valid),
    .blank     (blank),
    .key_err   (key_err)
  );
  always #5 clk = ~clk;
  task automatic expect_out(input string tag, input logic [3:0] n0, input logic [3:0] n1,
                            input logic [1:0] st, input logic op, input logic [3:0] bl, input logic err);
    exp_t e;
    e.tag = tag;
    e.v = {n0, n1, st, op, bl, err};
    q.push_back(e);
  endtask
  task automatic expect_rst(input string tag);
    expect_out(tag, 4'd0, 4'd0, 2'b00, 1'b0, 4'b1111, 1'b0);
  endtask
  task automatic check();
    exp_t e;
    logic [15:0] obs;
    vectors++;
    obs = {num_0, num_1, state, op_valid, blank, key_err};
    if (q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed %h, no expected entry", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.v) else begin
        miscompares++;
        $error("FAIL %s: observed n0=%h n1=%h st=%b op=%b blank=%b err=%b, expected n0=%h n1=%h st=%b op=%b blank=%b err=%b",
               e.tag, obs[15:12], obs[11:8], obs[7:6], obs[5], obs[4:1], obs[0],
               e.v[15:12], e.v[11:8], e.v[7:6], e.v[5], e.v[4:1], e.v[0]);
      end
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic key(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
    check();
  endtask
  initial begin
    idle(2);
    expect_rst("reset");
    check();
    rst = 1'b1;
    idle(1);
`ifdef AUTO_ADVANCE_EN
    expect_out("auto_a", 4'd1, 4'd0, 2'b01, 1'b0, 4'b1110, 1'b0); key(4'd1);
    expect_out("auto_b", 4'd1, 4'd2, 2'b10, 1'b1, 4'b0000, 1'b0); key(4'd2);
    expect_out("auto_add_ign", 4'd1, 4'd2, 2'b10, 1'b1, 4'b0000, 1'b0); key(4'hA);
    expect_out("auto_eq_ign", 4'd1, 4'd2, 2'b10, 1'b1, 4'b0000, 1'b0); key(4'hB);
    expect_out("auto_rsv", 4'd1, 4'd2, 2'b10, 1'b1, 4'b0000, 1'b1); key(4'hE);
    expect_rst("auto_clr"); key(4'hC);
`else
    expect_out("t1_a7", 4'd7, 4'd0, 2'b00, 1'b0, 4'b1110, 1'b0); key(4'd7); idle(3);
    expect_out("t1_add", 4'd7, 4'd0, 2'b01, 1'b0, 4'b1110, 1'b0); key(4'hA); idle(3);
    expect_out("t1_b5", 4'd7, 4'd5, 2'b01, 1'b0, 4'b1100, 1'b0); key(4'd5); idle(3);
    expect_out("t1_eq", 4'd7, 4'd5, 2'b10, 1'b1, 4'b0000, 1'b0); key(4'hB);
    expect_out("t1_idle_ign", 4'd7, 4'd5, 2'b10, 1'b1, 4'b0000, 1'b0); idle(3); check();
    expect_rst("t1_clr"); key(4'hC);
    expect_rst("t2_add_ign"); key(4'hA);
    expect_rst("t2_eq_ign"); key(4'hB);
    expect_out("t2_a3", 4'd3, 4'd0, 2'b00, 1'b0, 4'b1110, 1'b0); key(4'd3);
    expect_out("t2_a8", 4'd8, 4'd0, 2'b00, 1'b0, 4'b1110, 1'b0); key(4'd8);
    expect_rst("t2_clr"); key(4'hC);
    expect_out("t3_a4", 4'd4, 4'd0, 2'b00, 1'b0, 4'b1110, 1'b0); key(4'd4);
    expect_out("t3_add", 4'd4, 4'd0, 2'b01, 1'b0, 4'b1110, 1'b0); key(4'hA);
    expect_out("t3_b6", 4'd4, 4'd6, 2'b01, 1'b0, 4'b1100, 1'b0); key(4'd6);
    expect_rst("t3_clr"); key(4'hC);
    expect_out("t4_a9", 4'd9, 4'd0, 2'b00, 1'b0, 4'b1110, 1'b0); key(4'd9);
    expect_out("t4_rsv", 4'd9, 4'd0, 2'b00, 1'b0, 4'b1110, 1'b1); key(4'hE);
    expect_out("t4_err_drop", 4'd9, 4'd0, 2'b00, 1'b0, 4'b1110, 1'b0); idle(1); check();
    expect_out("t4_add", 4'd9, 4'd0, 2'b01, 1'b0, 4'b1110, 1'b0); key(4'hA);
    expect_out("t4_eq_no_b", 4'd9, 4'd0, 2'b01, 1'b0, 4'b1110, 1'b0); key(4'hB);
    expect_out("t4_add_in_b", 4'd9, 4'd0, 2'b01, 1'b0, 4'b1110, 1'b0); key(4'hA);
    expect_out("t4_b0", 4'd9, 4'd0, 2'b01, 1'b0, 4'b1100, 1'b0); key(4'd0);
    expect_out("t5_eq", 4'd9, 4'd0, 2'b10, 1'b1, 4'b0000, 1'b0); key(4'hB);
    expect_out("t5_hold9", 4'd9, 4'd0, 2'b10, 1'b1, 4'b0000, 1'b0); idle(9); check();
    expect_rst("t5_timeout"); idle(1); check();
    expect_out("t5b_a7", 4'd7, 4'd0, 2'b00, 1'b0, 4'b1110, 1'b0); key(4'd7);
    expect_out("t5b_add", 4'd7, 4'd0, 2'b01, 1'b0, 4'b1110, 1'b0); key(4'hA);
    expect_out("t5b_b5", 4'd7, 4'd5, 2'b01, 1'b0, 4'b1100, 1'b0); key(4'd5);
    expect_out("t5b_eq", 4'd7, 4'd5, 2'b10, 1'b1, 4'b0000, 1'b0); key(4'hB);
    idle(9);
    expect_out("t5b_key_at_expiry", 4'd2, 4'd0, 2'b00, 1'b0, 4'b1110, 1'b0); key(4'd2);
    expect_out("t5b_no_timer_in_a", 4'd2, 4'd0, 2'b00, 1'b0, 4'b1110, 1'b0); idle(12); check();
    expect_rst("t5b_clr"); key(4'hC);
    expect_out("t6_a1", 4'd1, 4'd0, 2'b00, 1'b0, 4'b1110, 1'b0); key(4'd1);
    expect_out("t6_add", 4'd1, 4'd0, 2'b01, 1'b0, 4'b1110, 1'b0); key(4'hA);
    expect_out("t6_b9", 4'd1, 4'd9, 2'b01, 1'b0, 4'b1100, 1'b0); key(4'd9);
    #2 rst = 1'b0;
    #1 expect_rst("t6_async_rst"); check();
    @(negedge clk) rst = 1'b1;
    expect_rst("t6_after_rst"); idle(1); check();
    expect_rst("t6_add_after_rst"); key(4'hA);
    expect_out("t6_a3", 4'd3, 4'd0, 2'b00, 1'b0, 4'b1110, 1'b0); key(4'd3);
`endif
    if (q.size() != 0) begin
      miscompares++;
      $error("FAIL scoreboard_leftover: observed %0d entries, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
